dff_bist_checker: RTL and testbench

- Synthesizable self-test engine for the team's D flip-flop cell with active-low asynchronous set (S) and reset (R), outputs Q/Qb.
- Drives the flip-flop's input pins and checks its Q/Qb responses: async set check, async clear check, then a pseudo-random D sequence with 1-clock latency checking.
- Reports pass/fail, error count, failing phase and first failing vector index.
- Sits beside a DUT flip-flop instance as on-chip BIST in place of a simulation-only bench.

---
 rtl/dff_bist_checker_pkg.sv | 26 ++
 rtl/dff_bist_checker_lfsr8.sv | 29 ++
 rtl/dff_bist_checker.sv | 135 +++++++++++++
 tb/tb_dff_bist_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_bist_checker_pkg.sv
// dff_bist_checker_pkg: shared state encoding, failure phase codes and LFSR taps
package dff_bist_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_SET  = 2'd1;
    localparam logic [1:0] PH_CLR  = 2'd2;
    localparam logic [1:0] PH_RUN  = 2'd3;

    // Feedback taps at bits 7,5,4,3 (x^8+x^6+x^5+x^4+1, shift left)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
    function automatic logic [7:0] legal_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/dff_bist_checker_lfsr8.sv
// dff_bist_checker_lfsr8: 8-bit Fibonacci LFSR with seed reload and step enable
module dff_bist_checker_lfsr8
    import dff_bist_checker_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic step_i,
    output logic bit_o
);

    localparam logic [7:0] INIT = legal_seed(SEED);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Reload wins over stepping so a new test always replays the same stream
    always_comb lfsr_d = load_i ? INIT : step_i ? {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;

    // LFSR state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) lfsr_q <= INIT;
        else       lfsr_q <= lfsr_d;

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/dff_bist_checker.sv
// dff_bist_checker: on-chip self-test of a D flip-flop with active-low async set/reset
module dff_bist_checker
    import dff_bist_checker_pkg::*;
#(
    parameter int         NUM_VEC = 64,
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         CNT_W   = 8,
    parameter int         IDX_W   = 6
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    output logic             dut_D,
    output logic             dut_S,
    output logic             dut_R,
    input  logic             dut_Q,
    input  logic             dut_Qb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       fail_phase,
    output logic [IDX_W-1:0] first_fail_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VEC - 1);

    state_t           state_q;
    logic [IDX_W-1:0] vec_idx_q;
    logic [IDX_W-1:0] exp_idx_q;
    logic             exp_d_q;

    logic             lfsr_bit;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             chk_en;
    logic             chk_exp;
    logic             chk_fail;
    logic [1:0]       chk_phase;
    logic [IDX_W-1:0] chk_idx;
    logic [CNT_W-1:0] err_d;

    dff_bist_checker_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_i  (R),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .bit_o  (lfsr_bit)
    );

    // Decide what the current cycle checks and how the error counter moves.
    // A RUN cycle checks the vector driven one cycle earlier; DRAIN checks the last one.
    always_comb begin
        lfsr_load = start && (state_q == ST_IDLE || state_q == ST_DONE);
        lfsr_step = (state_q == ST_CLR) || (state_q == ST_RUN && vec_idx_q != LAST);
        chk_en    = (state_q == ST_SET) || (state_q == ST_CLR) || (state_q == ST_DRAIN) ||
                    (state_q == ST_RUN && vec_idx_q != '0);
        chk_exp   = (state_q == ST_SET) ? 1'b1 : (state_q == ST_CLR) ? 1'b0 : exp_d_q;
        chk_phase = (state_q == ST_SET) ? PH_SET : (state_q == ST_CLR) ? PH_CLR : PH_RUN;
        chk_idx   = (state_q == ST_RUN || state_q == ST_DRAIN) ? exp_idx_q : '0;
        chk_fail  = chk_en && ((dut_Q != chk_exp) || (dut_Qb == dut_Q));
        err_d     = (chk_fail && !(&err_count)) ? err_count + 1'b1 : err_count;
    end

    // Test sequencer with registered DUT pins and result outputs
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q        <= ST_IDLE;
            dut_D          <= 1'b0;
            dut_S          <= 1'b1;
            dut_R          <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_phase     <= PH_NONE;
            first_fail_idx <= '0;
            vec_idx_q      <= '0;
            exp_idx_q      <= '0;
            exp_d_q        <= 1'b0;
        end else begin
            exp_d_q   <= dut_D;
            exp_idx_q <= vec_idx_q;
            err_count <= err_d;
            if (chk_fail && fail_phase == PH_NONE) begin
                fail_phase     <= chk_phase;
                first_fail_idx <= chk_idx;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q        <= ST_SET;
                        dut_S          <= 1'b0;
                        dut_D          <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        fail_phase     <= PH_NONE;
                        first_fail_idx <= '0;
                    end
                end
                ST_SET: begin
                    state_q <= ST_CLR;
                    dut_S   <= 1'b1;
                    dut_R   <= 1'b0;
                    dut_D   <= 1'b0;
                end
                ST_CLR: begin
                    state_q   <= ST_RUN;
                    dut_R     <= 1'b1;
                    dut_D     <= lfsr_bit;
                    vec_idx_q <= '0;
                end
                ST_RUN: begin
                    if (vec_idx_q == LAST) begin
                        state_q <= ST_DRAIN;
                        dut_D   <= 1'b0;
                    end else begin
                        vec_idx_q <= vec_idx_q + 1'b1;
                        dut_D     <= lfsr_bit;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (err_d == '0);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bist_checker.sv
// tb_dff_bist_checker: directed checks of the flip-flop BIST engine against a faultable flop model
module tb_dff_bist_checker;

    logic clk = 1'b0;
    logic R = 1'b1;
    logic start = 1'b0;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;
    int   n;

    always #5 clk = ~clk;

    // Three checkers: defaults, narrow error counter, zero seed
    logic       dD0, dS0, dR0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] ph0;
    logic [5:0] idx0;
    logic       dD1, dS1, dR1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [1:0] ph1;
    logic [5:0] idx1;
    logic       dD2, dS2, dR2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [1:0] ph2;
    logic [5:0] idx2;

    logic [2:0] dD, dS, dR, qo, qbo;
    logic [2:0] st = 3'b000;
    logic [2:0] dc = 3'b000;
    logic [2:0] dc2 = 3'b000;

    assign dD = {dD2, dD1, dD0};
    assign dS = {dS2, dS1, dS0};
    assign dR = {dR2, dR1, dR0};

    dff_bist_checker u_dut (
        .clk(clk), .R(R), .start(start), .dut_D(dD0), .dut_S(dS0), .dut_R(dR0),
        .dut_Q(qo[0]), .dut_Qb(qbo[0]), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_phase(ph0), .first_fail_idx(idx0)
    );

    dff_bist_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .R(R), .start(start), .dut_D(dD1), .dut_S(dS1), .dut_R(dR1),
        .dut_Q(qo[1]), .dut_Qb(qbo[1]), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_phase(ph1), .first_fail_idx(idx1)
    );

    dff_bist_checker #(.SEED(8'h00)) u_s0 (
        .clk(clk), .R(R), .start(start), .dut_D(dD2), .dut_S(dS2), .dut_R(dR2),
        .dut_Q(qo[2]), .dut_Qb(qbo[2]), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_phase(ph2), .first_fail_idx(idx2)
    );

    // Flop model. Modes: 0 healthy, 1 Q stuck 0, 2 ignores S, 3 ignores R, 4 Qb=Q, 5 two-cycle latency.
    // Pins only move on rising edges, so D is captured and async S/R applied mid-cycle.
    always_comb begin
        qo  = (mode == 1) ? 3'b000 : st;
        qbo = (mode == 4) ? qo : ~qo;
    end

    always @(clk) begin
        if (clk) begin
            st  <= (mode == 5) ? dc2 : dc;
            dc2 <= dc;
        end else begin
            st <= (st | (~dS & {3{mode != 2}})) & ~(~dR & {3{mode != 3}});
            dc <= dD;
        end
    end

    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int ones(input logic [7:0] seed);
        logic [7:0] s = seed;
        int c = 0;
        for (int i = 0; i < 64; i++) begin
            c += int'(s[0]);
            s = nxt(s);
        end
        return c;
    endfunction

    // Vector i fails under two-cycle latency when D[i] differs from D[i-1] (D[-1] is the clear phase's 0)
    function automatic int lat_errs(input logic [7:0] seed, input bit want_first);
        logic [7:0] s = seed;
        logic prev = 1'b0;
        int c = 0;
        int first = -1;
        for (int i = 0; i < 64; i++) begin
            if (s[0] != prev) begin
                if (first < 0) first = i;
                c++;
            end
            prev = s[0];
            s = nxt(s);
        end
        return want_first ? first : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run_test(input int pulse_at, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        chk("set_pins", {29'd0, dS0, dR0, dD0}, 32'b011);
        chk("busy_set", busy0, 1);
        chk("done_drop", done0, 0);
        chk("pass_low", pass0, 0);
        @(negedge clk);
        edges = 1;
        chk("clr_pins", {29'd0, dS0, dR0, dD0}, 32'b100);
        while (!done0 && edges < 200) begin
            @(negedge clk);
            edges++;
            start = (edges == pulse_at);
        end
        start = 1'b0;
        chk("latency", edges, 67);
        chk("busy_done", busy0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_phase", ph0, 0);
        chk("rst_idx", idx0, 0);
        chk("rst_pins", {29'd0, dS0, dR0, dD0}, 32'b110);
        R = 1'b0;

        mode = 0;
        run_test(20, n);
        chk("ok_pass", pass0, 1);
        chk("ok_err", err0, 0);
        chk("ok_phase", ph0, 0);
        chk("ok_seed0_pass", pass2, 1);

        mode = 1;
        run_test(0, n);
        chk("stuck_phase", ph0, 1);
        chk("stuck_idx", idx0, 0);
        chk("stuck_err", err0, 1 + ones(8'hA5));
        chk("stuck_pass", pass0, 0);
        chk("seed0_err", err2, 1 + ones(8'h01));
        chk("seed0_phase", ph2, 1);

        mode = 2;
        run_test(0, n);
        chk("nos_phase", ph0, 1);
        chk("nos_err", err0, 1);
        chk("nos_pass", pass0, 0);

        mode = 3;
        run_test(0, n);
        chk("nor_phase", ph0, 2);
        chk("nor_err", err0, 1);

        mode = 4;
        run_test(0, n);
        chk("qb_err", err0, 66);
        chk("qb_phase", ph0, 1);
        chk("sat_err", err1, 15);

        mode = 5;
        run_test(0, n);
        chk("lat_phase", ph0, 3);
        chk("lat_idx", idx0, lat_errs(8'hA5, 1'b1));
        chk("lat_err", err0, lat_errs(8'hA5, 1'b0));
        chk("lat_sat", err1, 15);

        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_pre_phase", ph0, 1);
        R = 1'b1;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_err", err0, 0);
        chk("abort_phase", ph0, 0);
        chk("abort_done", done0, 0);
        chk("abort_pins", {29'd0, dS0, dR0, dD0}, 32'b110);
        @(negedge clk);
        R = 1'b0;

        mode = 0;
        run_test(40, n);
        chk("rerun_pass", pass0, 1);
        chk("rerun_err", err0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
